// File: rtl/eval_core_pkg.sv
// Shared heap tags, primop codes, error codes and FSM state type for the
// evaluator and its memory port.
package lisp_defs;

  localparam int unsigned HDR_W  = 15;
  localparam int unsigned PROC_W = 4;
  localparam int unsigned NIL    = 0;

  localparam logic [HDR_W-1:0] TAG_NUMBER    = 15'd1;
  localparam logic [HDR_W-1:0] TAG_CONS      = 15'd2;
  localparam logic [HDR_W-1:0] TAG_PRIMITIVE = 15'd3;

  localparam logic [PROC_W-1:0] PRIMOP_ADD = 4'd0;
  localparam logic [PROC_W-1:0] PRIMOP_SUB = 4'd1;
  localparam logic [PROC_W-1:0] PRIMOP_MUL = 4'd2;

  localparam logic [3:0] STATE_ERROR  = 4'd0;
  localparam logic [3:0] EVAL_ERROR   = 4'd2;
  localparam logic [3:0] APPLY_ERROR  = 4'd3;
  localparam logic [3:0] STACK_ERROR  = 4'd4;
  localparam logic [3:0] ARG_ERROR    = 4'd5;
  localparam logic [3:0] PRIMOP_ERROR = 4'd6;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_MEM_WAIT, S_EVAL, S_APPLY,
    S_EVAL_LIST, S_EVAL_ARG, S_RETURN, S_DONE, S_ERROR
  } state_t;

  // Frame layout at the shell's 16-bit address/data configuration.
  typedef struct packed {
    logic [PROC_W-1:0] proc;
    logic [15:0]       acc;
    logic              first;
    logic [15:0]       args;
  } frame_t;

  function automatic logic is_primop(input logic [PROC_W-1:0] p);
    return (p == PRIMOP_ADD) || (p == PRIMOP_SUB) || (p == PRIMOP_MUL);
  endfunction

endpackage

// File: rtl/eval_core_if.sv
// Request/ready heap read port between the evaluator and the memory block.
interface eval_core_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  localparam int unsigned CELL_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ready;
  logic [14:0]       mem_header;
  logic [CELL_W-1:0] mem_car;
  logic [ADDR_W-1:0] mem_cdr;

  modport master (output mem_req, mem_addr,
                  input  mem_ready, mem_header, mem_car, mem_cdr);
  modport slave  (input  mem_req, mem_addr,
                  output mem_ready, mem_header, mem_car, mem_cdr);
endinterface

// File: rtl/eval_core_stack.sv
// Synchronous LIFO of suspended evaluation frames; top entry is combinational.
module eval_stack #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    top_idx;
  logic [IW-1:0]    wr_idx;
  logic             replace;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign top_idx = IW'(cnt - CW'(1));
  assign wr_idx  = IW'(cnt);
  assign replace = push && pop && !empty;
  assign dout    = empty ? '0 : mem[top_idx];

  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else if (replace) cnt <= cnt;
    else if (push && !full) cnt <= cnt + CW'(1);
    else if (pop && !empty) cnt <= cnt - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (replace) mem[top_idx] <= din;
    else if (push && !full) mem[wr_idx] <= din;
  end
endmodule

// File: rtl/eval_core.sv
// Nested primitive-application evaluator: walks a heap expression over a
// request/ready port, suspending outer applications on an explicit stack.
module eval_core
  import lisp_defs::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] root_addr,
  eval_core_if.master       mem,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              error,
  output logic [3:0]        error_code
);
  localparam int unsigned CELL_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

  typedef struct packed {
    logic [PROC_W-1:0] proc;
    logic [DATA_W-1:0] acc;
    logic              first;
    logic [ADDR_W-1:0] args;
  } stack_frame_t;

  state_t            state, ret_st;
  logic [HDR_W-1:0]  hdr_q;
  logic [CELL_W-1:0] car_q;
  logic [ADDR_W-1:0] cdr_q;
  logic [ADDR_W-1:0] expr, args;
  logic [DATA_W-1:0] acc;
  logic [PROC_W-1:0] proc;
  logic              first;

  stack_frame_t st_din, st_top;
  logic         st_push, st_pop, st_clear, st_full, st_empty;
  logic         fault;
  logic [3:0]   fault_code;
  logic         is_num, is_cons;

  function automatic logic [DATA_W-1:0] combine(input logic [PROC_W-1:0] p,
                                                input logic f,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] v);
    case (p)
      PRIMOP_ADD: combine = a + v;
      PRIMOP_SUB: combine = f ? v : a - v;
      PRIMOP_MUL: combine = a * v;
      default:    combine = a;
    endcase
  endfunction

  assign is_num   = (hdr_q == TAG_NUMBER);
  assign is_cons  = (hdr_q == TAG_CONS);
  assign st_din   = '{proc: proc, acc: acc, first: first, args: args};
  assign st_push  = (state == S_EVAL_ARG) && is_cons && !st_full;
  assign st_pop   = (state == S_RETURN) && !st_empty && !fault;
  assign st_clear = start && ((state == S_IDLE) || (state == S_DONE));

  eval_stack #(.DEPTH(STACK_DEPTH), .WIDTH($bits(stack_frame_t))) u_stack (
    .clk(clk), .rst(rst), .clear(st_clear), .push(st_push), .pop(st_pop),
    .din(st_din), .dout(st_top), .full(st_full), .empty(st_empty)
  );

  // Every decode-state error is detected here so the FSM has one error path.
  always_comb begin
    fault      = 1'b0;
    fault_code = STATE_ERROR;
    case (state)
      S_IDLE, S_FETCH, S_MEM_WAIT, S_EVAL_LIST, S_DONE, S_ERROR: ;
      S_EVAL:
        if (!is_num && !is_cons) begin fault = 1'b1; fault_code = EVAL_ERROR; end
      S_APPLY:
        if (hdr_q != TAG_PRIMITIVE) begin fault = 1'b1; fault_code = APPLY_ERROR; end
      S_EVAL_ARG:
        if (is_num) begin
          if (!is_primop(proc)) begin fault = 1'b1; fault_code = PRIMOP_ERROR; end
        end else if (is_cons) begin
          if (st_full) begin fault = 1'b1; fault_code = STACK_ERROR; end
        end else begin
          fault = 1'b1; fault_code = ARG_ERROR;
        end
      S_RETURN:
        if (!st_empty && !is_primop(st_top.proc)) begin
          fault = 1'b1; fault_code = PRIMOP_ERROR;
        end
      default: fault = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      ret_st       <= S_IDLE;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= '0;
      hdr_q        <= '0;
      car_q        <= '0;
      cdr_q        <= '0;
      expr         <= '0;
      args         <= '0;
      acc          <= '0;
      proc         <= '0;
      first        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      result       <= '0;
      error_code   <= '0;
    end else if (fault) begin
      state       <= S_ERROR;
      mem.mem_req <= 1'b0;
      busy        <= 1'b0;
      error       <= 1'b1;
      error_code  <= fault_code;
    end else begin
      case (state)
        S_IDLE, S_DONE:
          if (start) begin
            expr  <= root_addr;
            acc   <= '0;
            done  <= 1'b0;
            busy  <= 1'b1;
            state <= S_FETCH;
          end
        S_FETCH: begin
          mem.mem_req <= 1'b1; mem.mem_addr <= expr; ret_st <= S_EVAL; state <= S_MEM_WAIT;
        end
        S_MEM_WAIT:
          if (mem.mem_ready) begin
            hdr_q       <= mem.mem_header;
            car_q       <= mem.mem_car;
            cdr_q       <= mem.mem_cdr;
            mem.mem_req <= 1'b0;
            state       <= ret_st;
          end
        S_EVAL:
          if (is_num) begin
            result <= car_q[DATA_W-1:0];
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= S_DONE;
          end else begin
            args <= cdr_q;
            mem.mem_req <= 1'b1; mem.mem_addr <= car_q[ADDR_W-1:0];
            ret_st <= S_APPLY; state <= S_MEM_WAIT;
          end
        S_APPLY: begin
          proc  <= car_q[PROC_W-1:0];
          first <= 1'b1;
          acc   <= (car_q[PROC_W-1:0] == PRIMOP_MUL) ? DATA_W'(1) : '0;
          if (args == ADDR_W'(NIL)) state <= S_RETURN;
          else begin
            mem.mem_req <= 1'b1; mem.mem_addr <= args; ret_st <= S_EVAL_LIST; state <= S_MEM_WAIT;
          end
        end
        S_EVAL_LIST: begin
          args <= cdr_q;
          mem.mem_req <= 1'b1; mem.mem_addr <= car_q[ADDR_W-1:0];
          ret_st <= S_EVAL_ARG; state <= S_MEM_WAIT;
        end
        S_EVAL_ARG:
          if (is_num) begin
            acc   <= combine(proc, first, acc, car_q[DATA_W-1:0]);
            first <= 1'b0;
            if (args == ADDR_W'(NIL)) state <= S_RETURN;
            else begin
              mem.mem_req <= 1'b1; mem.mem_addr <= args; ret_st <= S_EVAL_LIST; state <= S_MEM_WAIT;
            end
          end else begin
            // Outer frame was pushed this cycle; descend into the nested call.
            args <= cdr_q;
            mem.mem_req <= 1'b1; mem.mem_addr <= car_q[ADDR_W-1:0];
            ret_st <= S_APPLY; state <= S_MEM_WAIT;
          end
        S_RETURN:
          if (st_empty) begin
            result <= acc;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= S_DONE;
          end else begin
            acc   <= combine(st_top.proc, st_top.first, st_top.acc, acc);
            first <= 1'b0;
            proc  <= st_top.proc;
            args  <= st_top.args;
            if (st_top.args == ADDR_W'(NIL)) state <= S_RETURN;
            else begin
              mem.mem_req <= 1'b1; mem.mem_addr <= st_top.args;
              ret_st <= S_EVAL_LIST; state <= S_MEM_WAIT;
            end
          end
        S_ERROR: ;
        default: state <= S_ERROR;
      endcase
    end
  end
endmodule

// File: tb/tb_eval_core.sv
// Self-checking bench for eval_core: behavioural heap memory with random
// stalls, expressions built bottom-up with their values computed arithmetically.
module tb_eval_core;
  import lisp_defs::*;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned SD = 2;
  localparam int unsigned HEAP = 512;
  localparam int unsigned BUDGET = 3000;
  localparam logic [14:0] TAG_SYM = 15'd4;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [AW-1:0] root_addr;
  logic          busy, done, error;
  logic [DW-1:0] result;
  logic [3:0]    error_code;

  eval_core_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();

  eval_core #(.ADDR_W(AW), .DATA_W(DW), .STACK_DEPTH(SD)) dut (
    .clk(clk), .rst(rst), .start(start), .root_addr(root_addr), .mem(mif),
    .busy(busy), .done(done), .result(result), .error(error), .error_code(error_code)
  );

  always #5 clk = ~clk;

  logic [14:0] hp_hdr [HEAP];
  logic [15:0] hp_car [HEAP];
  logic [15:0] hp_cdr [HEAP];
  int unsigned hp_next = 1;

  int unsigned nvec = 0;
  int unsigned nfail = 0;
  bit          fixed_lat = 1'b1;
  int unsigned stall = 0;
  int unsigned hs_viol = 0;
  logic          p_req = 1'b0, p_rdy = 1'b0;
  logic [AW-1:0] p_addr = '0;

  // Memory responder plus handshake-rule monitor, evaluated before the response changes.
  always @(negedge clk) begin
    int unsigned a;
    if (!rst && p_req && p_rdy && mif.mem_req) hs_viol++;
    if (!rst && p_req && !p_rdy && (!mif.mem_req || mif.mem_addr != p_addr)) hs_viol++;
    p_req = mif.mem_req;
    p_addr = mif.mem_addr;
    mif.mem_ready = 1'b0;
    if (!mif.mem_req) stall = fixed_lat ? 0 : $urandom_range(0, 5);
    else if (stall != 0) stall--;
    else begin
      a = 32'(mif.mem_addr) % HEAP;
      mif.mem_ready  = 1'b1;
      mif.mem_header = hp_hdr[a];
      mif.mem_car    = hp_car[a];
      mif.mem_cdr    = hp_cdr[a];
    end
    p_rdy = mif.mem_ready;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned new_cell(input logic [14:0] h, input logic [15:0] a,
                                           input logic [15:0] d);
    hp_hdr[hp_next] = h;
    hp_car[hp_next] = a;
    hp_cdr[hp_next] = d;
    hp_next++;
    return hp_next - 1;
  endfunction

  function automatic int unsigned mk_call(input int unsigned op, input int unsigned el[8],
                                          input int n);
    int unsigned l = NIL;
    for (int i = n - 1; i >= 0; i--) l = new_cell(TAG_CONS, 16'(el[i]), 16'(l));
    return new_cell(TAG_CONS, 16'(op), 16'(l));
  endfunction

  function automatic int unsigned mk_app(input logic [3:0] p, input int unsigned el[8],
                                         input int n);
    return mk_call(new_cell(TAG_PRIMITIVE, 16'(p), 16'(NIL)), el, n);
  endfunction

  function automatic logic [15:0] apply_op(input logic [3:0] p, input logic [15:0] v[8],
                                           input int n);
    logic [15:0] r;
    if (p == PRIMOP_MUL) begin
      r = 16'd1;
      for (int i = 0; i < n; i++) r = r * v[i];
    end else if (p == PRIMOP_ADD) begin
      r = 16'd0;
      for (int i = 0; i < n; i++) r = r + v[i];
    end else begin
      r = (n == 0) ? 16'd0 : v[0];
      for (int i = 1; i < n; i++) r = r - v[i];
    end
    return r;
  endfunction

  // Chain of `levels` nested applications below the root, built innermost first.
  function automatic int unsigned build_chain(input int unsigned levels, output logic [15:0] val);
    int unsigned inner = NIL;
    logic [15:0] inner_v = '0;
    for (int lv = int'(levels); lv >= 0; lv--) begin
      int unsigned el[8];
      logic [15:0] vv[8];
      logic [15:0] x;
      logic [3:0] p;
      int n, pos, k;
      p = 4'($urandom_range(0, 2));
      n = int'($urandom_range(0, 3));
      pos = (lv < int'(levels)) ? int'($urandom_range(0, n)) : -1;
      k = 0;
      for (int i = 0; i <= n; i++) begin
        if (i == pos) begin el[k] = inner; vv[k] = inner_v; k++; end
        if (i < n) begin
          x = 16'($urandom_range(0, 65535));
          el[k] = new_cell(TAG_NUMBER, x, 16'(NIL));
          vv[k] = x;
          k++;
        end
      end
      inner = mk_app(p, el, k);
      inner_v = apply_op(p, vv, k);
    end
    val = inner_v;
    return inner;
  endfunction

  task automatic run(input string tag, input int unsigned root, input bit exp_err,
                     input logic [15:0] exp_val, input logic [3:0] exp_code);
    int unsigned cyc = 0;
    @(negedge clk);
    start = 1'b1;
    root_addr = AW'(root);
    @(negedge clk);
    start = 1'b0;
    while (!done && !error && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_timeout"}, 32'(cyc < BUDGET), 32'd1);
    check({tag, "_error"}, 32'(error), 32'(exp_err));
    if (exp_err) check({tag, "_code"}, 32'(error_code), 32'(exp_code));
    else check({tag, "_result"}, 32'(result), 32'(exp_val));
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_result"}, 32'(result), 32'd0);
    check({tag, "_code"}, 32'(error_code), 32'd0);
    check({tag, "_req"}, 32'(mif.mem_req), 32'd0);
    check({tag, "_addr"}, 32'(mif.mem_addr), 32'd0);
  endtask

  initial begin
    int unsigned el[8];
    int unsigned r, inner, op, cyc;
    logic [15:0] ev;

    rst = 1'b1; start = 1'b0; root_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk) rst = 1'b0;

    // Number root with one-cycle memory: done exactly three edges after start.
    r = new_cell(TAG_NUMBER, 16'h002A, 16'(NIL));
    @(negedge clk);
    start = 1'b1;
    root_addr = AW'(r);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check("num_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("num_done_early", 32'(done), 32'd0);
    @(posedge clk); #1;
    check("num_done", 32'(done), 32'd1);
    check("num_result", 32'(result), 32'h2A);

    fixed_lat = 1'b0;

    hp_next = 1;
    for (int i = 0; i < 3; i++) el[i] = new_cell(TAG_NUMBER, 16'(i + 1), 16'(NIL));
    run("add123", mk_app(PRIMOP_ADD, el, 3), 1'b0, 16'h0006, 4'd0);

    hp_next = 1;
    el[0] = new_cell(TAG_NUMBER, 16'd2, 16'(NIL));
    el[1] = new_cell(TAG_NUMBER, 16'd3, 16'(NIL));
    inner = mk_app(PRIMOP_ADD, el, 2);
    el[0] = new_cell(TAG_NUMBER, 16'd10, 16'(NIL));
    el[1] = inner;
    el[2] = new_cell(TAG_NUMBER, 16'd1, 16'(NIL));
    run("sub_nested", mk_app(PRIMOP_SUB, el, 3), 1'b0, 16'h0004, 4'd0);
    run("mul_empty", mk_app(PRIMOP_MUL, el, 0), 1'b0, 16'h0001, 4'd0);
    el[0] = new_cell(TAG_NUMBER, 16'h0100, 16'(NIL));
    el[1] = el[0];
    run("mul_wrap", mk_app(PRIMOP_MUL, el, 2), 1'b0, 16'h0000, 4'd0);

    for (int i = 0; i < 24; i++) begin
      hp_next = 1;
      r = build_chain($urandom_range(0, SD), ev);
      run("rand", r, 1'b0, ev, 4'd0);
    end
    check("handshake_rules", hs_viol, 32'd0);

    // Reset while a read is outstanding, then a clean evaluation.
    hp_next = 1;
    for (int i = 0; i < 3; i++) el[i] = new_cell(TAG_NUMBER, 16'(10 * (i + 1)), 16'(NIL));
    r = mk_app(PRIMOP_ADD, el, 3);
    @(negedge clk);
    start = 1'b1;
    root_addr = AW'(r);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!mif.mem_req && cyc < 100) begin @(negedge clk); cyc++; end
    check("midrst_req_seen", 32'(cyc < 100), 32'd1);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    @(negedge clk) rst = 1'b0;
    el[0] = new_cell(TAG_NUMBER, 16'd4, 16'(NIL));
    el[1] = new_cell(TAG_NUMBER, 16'd5, 16'(NIL));
    run("add45", mk_app(PRIMOP_ADD, el, 2), 1'b0, 16'h0009, 4'd0);

    hp_next = 1;
    r = build_chain(SD + 1, ev);
    run("overflow", r, 1'b1, 16'h0, STACK_ERROR);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("sticky_error", 32'(error), 32'd1);
    check("sticky_busy", 32'(busy), 32'd0);
    check("sticky_req", 32'(mif.mem_req), 32'd0);
    check("sticky_code", 32'(error_code), 32'(STACK_ERROR));
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("err_rst_error", 32'(error), 32'd0);
    check("err_rst_code", 32'(error_code), 32'd0);
    @(negedge clk) rst = 1'b0;

    hp_next = 1;
    el[0] = new_cell(TAG_NUMBER, 16'd1, 16'(NIL));
    op = new_cell(TAG_NUMBER, 16'd5, 16'(NIL));
    run("op_number", mk_call(op, el, 1), 1'b1, 16'h0, APPLY_ERROR);
    do_reset();

    el[0] = new_cell(TAG_NUMBER, 16'd1, 16'(NIL));
    el[1] = new_cell(TAG_PRIMITIVE, 16'(PRIMOP_ADD), 16'(NIL));
    run("arg_prim", mk_app(PRIMOP_ADD, el, 2), 1'b1, 16'h0, ARG_ERROR);
    do_reset();

    el[0] = new_cell(TAG_NUMBER, 16'd1, 16'(NIL));
    run("bad_primop", mk_app(4'd7, el, 1), 1'b1, 16'h0, PRIMOP_ERROR);
    do_reset();

    r = new_cell(TAG_SYM, 16'd3, 16'(NIL));
    run("root_symbol", r, 1'b1, 16'h0, EVAL_ERROR);
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
